car_position_controller: RTL and testbench



---
 rtl/car_position_controller_pkg.sv | 16 +
 rtl/frame_divider.sv | 22 ++
 rtl/car_position_controller.sv | 111 +++++++++++
 tb/tb_car_position_controller.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/car_position_controller_pkg.sv
// car_position_controller_pkg: car geometry, road bounds and crash FSM encodings
package car_position_controller_pkg;
    localparam int CAR_WIDTH  = 16;
    localparam int ROAD_X_MIN = 0;
    localparam int ROAD_X_MAX = 256 - CAR_WIDTH;
    typedef enum logic [1:0] {
        DRIVE   = 2'd0,
        CRASH   = 2'd1,
        RESPAWN = 2'd2
    } state_t;
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/frame_divider.sv
// frame_divider: modulo-N counter advanced by en, with sync clear and a wrap pulse
module frame_divider #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    logic last;
    always_comb begin
        last  = cnt_q == W'(N - 1);
        wrap  = en && last;
        cnt_d = clr ? '0 : en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end
endmodule

// File: rtl/car_position_controller.sv
// car_position_controller: per-frame steering, speed, distance and crash/respawn sequencing
module car_position_controller
    import car_position_controller_pkg::*;
#(
    parameter int X_MIN        = ROAD_X_MIN,
    parameter int X_MAX        = ROAD_X_MAX,
    parameter int X_CENTER     = 120,
    parameter int Y_POS        = 400,
    parameter int STEP_X       = 2,
    parameter int SPEED_MAX    = 15,
    parameter int ACCEL_DIV    = 8,
    parameter int CRASH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refresh_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_accel,
    input  logic        collision,
    output logic [7:0]  car_position_x,
    output logic [9:0]  car_position_y,
    output logic [3:0]  speed,
    output logic [15:0] distance,
    output logic        crashed
);
    localparam int CW = $clog2(CRASH_FRAMES + 1);
    state_t state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [3:0] speed_q, speed_d;
    logic [15:0] dist_q, dist_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic crashed_q, crashed_d, latch_q, latch_d;
    logic hit, div_en, div_clr, wrap;
    logic [8:0] x_dec, x_inc;
    assign hit     = latch_q || collision;
    assign div_en  = refresh_tick && state_q == DRIVE && !hit;
    assign div_clr = refresh_tick && state_q == RESPAWN;
    frame_divider #(.N(ACCEL_DIV)) u_div (
        .clk  (clk),
        .reset(reset),
        .en   (div_en),
        .clr  (div_clr),
        .wrap (wrap)
    );
    // 9-bit arithmetic keeps both clamps free of wraparound
    assign x_dec = {1'b0, x_q} - 9'(STEP_X);
    assign x_inc = {1'b0, x_q} + 9'(STEP_X);
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        speed_d = speed_q;
        dist_d  = dist_q;
        cnt_d   = cnt_q;
        latch_d = state_q == DRIVE && hit;
        if (refresh_tick) begin
            latch_d = 1'b0;
            case (state_q)
                DRIVE: begin
                    if (hit) begin
                        state_d = CRASH;
                        speed_d = '0;
                        cnt_d   = CW'(CRASH_FRAMES - 1);
                    end else begin
                        if (btn_left && !btn_right)
                            x_d = ({1'b0, x_q} < 9'(X_MIN + STEP_X)) ? 8'(X_MIN) : x_dec[7:0];
                        else if (btn_right && !btn_left)
                            x_d = (x_inc > 9'(X_MAX)) ? 8'(X_MAX) : x_inc[7:0];
                        dist_d = sat_add16(dist_q, speed_q);
                        if (wrap)
                            speed_d = btn_accel ? ((speed_q == 4'(SPEED_MAX)) ? speed_q : speed_q + 1'b1)
                                                : ((speed_q == 4'd0) ? speed_q : speed_q - 1'b1);
                    end
                end
                CRASH: begin
                    state_d = (cnt_q == '0) ? RESPAWN : CRASH;
                    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
                end
                default: begin
                    state_d = DRIVE;
                    x_d     = 8'(X_CENTER);
                end
            endcase
        end
        crashed_d = state_d != DRIVE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DRIVE;
            x_q       <= 8'(X_CENTER);
            speed_q   <= '0;
            dist_q    <= '0;
            cnt_q     <= '0;
            crashed_q <= 1'b0;
            latch_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            speed_q   <= speed_d;
            dist_q    <= dist_d;
            cnt_q     <= cnt_d;
            crashed_q <= crashed_d;
            latch_q   <= latch_d;
        end
    end
    assign car_position_x = x_q;
    assign car_position_y = 10'(Y_POS);
    assign speed          = speed_q;
    assign distance       = dist_q;
    assign crashed        = crashed_q;
endmodule

// File: tb/tb_car_position_controller.sv
// tb_car_position_controller: directed sequence with a behavioural model feeding a scoreboard queue
module tb_car_position_controller;
    logic clk = 1'b0, reset = 1'b1, refresh_tick = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_accel = 1'b0, collision = 1'b0;
    logic [7:0] car_position_x;
    logic [9:0] car_position_y;
    logic [3:0] speed;
    logic [15:0] distance;
    logic crashed;
    int cmp = 0, errs = 0;
    int m_x, m_spd, m_dist, m_state, m_div, m_cnt;
    bit m_latch;
    logic [38:0] sb[$];
    string tags[$];

    always #5 clk = ~clk;

    car_position_controller dut (
        .clk           (clk),
        .reset         (reset),
        .refresh_tick  (refresh_tick),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_accel     (btn_accel),
        .collision     (collision),
        .car_position_x(car_position_x),
        .car_position_y(car_position_y),
        .speed         (speed),
        .distance      (distance),
        .crashed       (crashed)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        cmp++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [38:0] model_out();
        return {8'(m_x), 10'd400, 4'(m_spd), 16'(m_dist), m_state != 0};
    endfunction

    // expected value queued with the stimulus, popped once the edge has produced it
    task automatic step(input string tag);
        sb.push_back(model_out());
        tags.push_back(tag);
        @(posedge clk);
        #1;
        check(tags.pop_front(), {25'd0, car_position_x, car_position_y, speed, distance, crashed},
              {25'd0, sb.pop_front()});
    endtask

    task automatic model_reset();
        m_x = 120; m_spd = 0; m_dist = 0; m_state = 0; m_div = 0; m_cnt = 0; m_latch = 0;
    endtask

    task automatic rst(input int n);
        repeat (n) begin
            reset = 1; refresh_tick = 1; collision = 1; btn_accel = 1;
            model_reset();
            step("reset");
        end
        reset = 0; refresh_tick = 0; collision = 0; btn_accel = 0;
    endtask

    task automatic tick(input bit l, input bit r, input bit a, input bit c, input string tag);
        bit hit;
        int old;
        btn_left = l; btn_right = r; btn_accel = a; collision = c; refresh_tick = 1;
        hit = m_latch || c;
        old = m_spd;
        if (m_state == 0) begin
            if (hit) begin
                m_state = 1; m_spd = 0; m_cnt = 59;
            end else begin
                if (l && !r) m_x = (m_x - 2 < 0) ? 0 : m_x - 2;
                else if (r && !l) m_x = (m_x + 2 > 240) ? 240 : m_x + 2;
                m_dist = (m_dist + old > 65535) ? 65535 : m_dist + old;
                if (m_div == 7) begin
                    m_div = 0;
                    m_spd = a ? (old == 15 ? 15 : old + 1) : (old == 0 ? 0 : old - 1);
                end else m_div++;
            end
        end else if (m_state == 1) begin
            if (m_cnt == 0) m_state = 2; else m_cnt--;
        end else begin
            m_x = 120; m_div = 0; m_state = 0;
        end
        m_latch = 0;
        step(tag);
        refresh_tick = 0; collision = 0;
    endtask

    task automatic idle(input int n, input bit c);
        repeat (n) begin
            collision = c; refresh_tick = 0;
            if (c && m_state == 0) m_latch = 1;
            step("idle");
        end
        collision = 0;
    endtask

    initial begin
        model_reset();
        rst(3);
        repeat (2) tick(0, 0, 0, 0, "idle_tick");
        check("reset_x", car_position_x, 120);
        check("reset_y", car_position_y, 400);
        check("reset_speed", speed, 0);
        repeat (70) tick(0, 1, 0, 0, "steer_right");
        check("clamp_right", car_position_x, 240);
        repeat (130) tick(1, 0, 0, 0, "steer_left");
        check("clamp_left", car_position_x, 0);
        repeat (5) tick(1, 1, 0, 0, "steer_both");
        check("both_hold", car_position_x, 0);
        repeat (8) tick(0, 0, 1, 0, "accel");
        check("speed_after_8", speed, 1);
        repeat (112) tick(0, 0, 1, 0, "accel");
        check("speed_after_120", speed, 15);
        repeat (10) tick(0, 0, 1, 0, "accel_sat");
        repeat (8) tick(0, 0, 0, 0, "decel");
        check("speed_decel", speed, 14);
        idle(3, 0);
        repeat (100) tick(0, 1, 1, 0, "accel_right");
        check("x_200", car_position_x, 200);
        repeat (4300) tick(0, 0, 1, 0, "dist_run");
        check("dist_sat", distance, 16'hFFFF);
        idle(1, 1);
        idle(4, 0);
        tick(0, 0, 1, 0, "latched_crash");
        check("crash_speed", speed, 0);
        check("crash_flag", crashed, 1);
        idle(1, 1);
        for (int i = 0; i < 60; i++) tick(1, 0, 1, i < 3, "crash");
        check("respawn_crashed", crashed, 1);
        check("crash_x_hold", car_position_x, 200);
        tick(0, 0, 0, 0, "respawn");
        check("respawn_x", car_position_x, 120);
        check("respawn_clear", crashed, 0);
        tick(0, 1, 0, 0, "drive_again");
        tick(0, 1, 0, 1, "tick_collision");
        check("tick_crash", crashed, 1);
        repeat (30) tick(0, 0, 0, 0, "crash2");
        rst(1);
        check("mid_crash_reset", crashed, 0);
        check("mid_crash_dist", distance, 0);
        repeat (2) tick(0, 0, 0, 0, "post_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
